// File: rtl/serial_cmp_sched_if.sv
// Bundle of the requester bus and the comparator-slice link for serial_cmp_sched.
// The slave modport is the scheduler's view; master is what drives it.
interface serial_cmp_sched_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  parameter int IDW   = 1
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        owner;
  logic                  done;
  logic                  a_gt;
  logic                  b_gt;
  logic                  eq;
  logic                  cmp_en;
  logic                  cmp_in1;
  logic                  cmp_in2;
  logic                  cmp_in1_gr;
  logic                  cmp_in2_gr;
  logic                  cmp_eq;
  logic                  cmp_err;

  modport slave (
    input  req, op_a, op_b, cmp_in1_gr, cmp_in2_gr, cmp_eq,
    output gnt, owner, done, a_gt, b_gt, eq, cmp_en, cmp_in1, cmp_in2, cmp_err
  );

  modport master (
    output req, op_a, op_b, cmp_in1_gr, cmp_in2_gr, cmp_eq,
    input  gnt, owner, done, a_gt, b_gt, eq, cmp_en, cmp_in1, cmp_in2, cmp_err
  );
endinterface

// File: rtl/serial_cmp_sched.sv
// Round-robin scheduler sharing one 1-bit comparator slice among NREQ requesters;
// walks latched operands MSB-first and stops at the first differing bit.
module serial_cmp_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  parameter int IDW   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_cmp_sched_if.slave  bus
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [IW-1:0]     idx_q;
  logic [IDW-1:0]    rr_q, owner_q;
  logic [NREQ-1:0]   gnt_q;
  logic              done_q, agt_q, bgt_q, eq_q, err_q;

  logic              pick_vld_d;
  logic [IDW-1:0]    pick_d;
  logic [WIDTH-1:0]  sel_a_d, sel_b_d;
  logic              res_onehot;

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] o);
    int n;
    n = int'(o) + 1;
    if (n >= NREQ) n = 0;
    return IDW'(n);
  endfunction

  // Scan downward from the farthest offset so the nearest set bit at/after rr_q wins.
  always_comb begin
    int cand;
    int pick_int;
    pick_vld_d = 1'b0;
    pick_d     = '0;
    pick_int   = 0;
    cand       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = int'(rr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (bus.req[cand]) begin
        pick_vld_d = 1'b1;
        pick_int   = cand;
      end
    end
    pick_d  = IDW'(pick_int);
    sel_a_d = bus.op_a[pick_int*WIDTH +: WIDTH];
    sel_b_d = bus.op_b[pick_int*WIDTH +: WIDTH];
  end

  assign res_onehot = $onehot({bus.cmp_in1_gr, bus.cmp_in2_gr, bus.cmp_eq});

  assign bus.cmp_en  = (state_q == CMP);
  assign bus.cmp_in1 = (state_q == CMP) & a_q[idx_q];
  assign bus.cmp_in2 = (state_q == CMP) & b_q[idx_q];

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.done    = done_q;
  assign bus.a_gt    = agt_q;
  assign bus.b_gt    = bgt_q;
  assign bus.eq      = eq_q;
  assign bus.cmp_err = err_q;

  // Operand registers carry no reset; they are only read while CMP is active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      idx_q   <= IW'(WIDTH - 1);
      done_q  <= 1'b0;
      agt_q   <= 1'b0;
      bgt_q   <= 1'b0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            a_q     <= sel_a_d;
            b_q     <= sel_b_d;
            gnt_q   <= NREQ'(1) << pick_d;
            owner_q <= pick_d;
            idx_q   <= IW'(WIDTH - 1);
            state_q <= CMP;
          end
        end
        CMP: begin
          if (!res_onehot) begin
            err_q   <= 1'b1;
            {agt_q, bgt_q, eq_q} <= 3'b001;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (bus.cmp_in1_gr) begin
            {agt_q, bgt_q, eq_q} <= 3'b100;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (bus.cmp_in2_gr) begin
            {agt_q, bgt_q, eq_q} <= 3'b010;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (idx_q == '0) begin
            {agt_q, bgt_q, eq_q} <= 3'b001;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          rr_q    <= next_ptr(owner_q);
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_cmp_sched.sv
// Bench for serial_cmp_sched with a behavioural 1-bit comparator (or an error stub)
// on the comparator link; results are checked through an expectation queue.
module tb_serial_cmp_sched;
  localparam int WIDTH = 8;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;

  typedef struct {
    int         owner;
    logic [2:0] res;   // {a_gt, b_gt, eq}
    int         k;
  } exp_t;

  typedef struct {
    logic [1:0] req;
    logic [7:0] a0, b0, a1, b1;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic stub;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sbq[$];
  vec_t tbl[8];

  serial_cmp_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  serial_cmp_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Comparator slice: a real 1-bit comparator, or a stub that reports gt and eq together.
  always_comb begin
    bus.cmp_in1_gr = bus.cmp_in1 & ~bus.cmp_in2;
    bus.cmp_in2_gr = ~bus.cmp_in1 & bus.cmp_in2;
    bus.cmp_eq     = ~(bus.cmp_in1 ^ bus.cmp_in2);
    if (stub && bus.cmp_en) begin
      bus.cmp_in1_gr = 1'b1;
      bus.cmp_in2_gr = 1'b0;
      bus.cmp_eq     = 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] r, input logic [7:0] a0, b0, a1, b1,
                              input int ow, input logic [2:0] res, input int k);
    vec_t v;
    v.req = r; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
    v.e.owner = ow; v.e.res = res; v.e.k = k;
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_gnt"},   32'(bus.gnt), 0);
    chk({tag, "_owner"}, 32'(bus.owner), 0);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk({tag, "_flags"}, 32'({bus.a_gt, bus.b_gt, bus.eq}), 0);
    chk({tag, "_cmp"},   32'({bus.cmp_en, bus.cmp_in1, bus.cmp_in2}), 0);
    chk({tag, "_err"},   32'(bus.cmp_err), 0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one request from a negedge; wait for done, then compare against the queue head.
  task automatic do_op(input string nm, input logic [1:0] r, input logic [7:0] a0, b0, a1, b1,
                       input exp_t e, input bit keep);
    int   cnt;
    bit   got;
    exp_t q;
    bus.req  = r;
    bus.op_a = {a1, a0};
    bus.op_b = {b1, b0};
    sbq.push_back(e);
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < WIDTH + 6) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) chk({nm, "_gnt_at_grant"}, 32'(bus.gnt), 32'(1) << e.owner);
      if (bus.done) got = 1'b1;
    end
    q = sbq.pop_front();
    chk({nm, "_done_seen"}, 32'(got), 1);
    if (got) begin
      chk({nm, "_latency"}, cnt, q.k + 1);
      chk({nm, "_owner"},   32'(bus.owner), q.owner);
      chk({nm, "_result"},  32'({bus.a_gt, bus.b_gt, bus.eq}), 32'(q.res));
      chk({nm, "_gnt_held"}, 32'(bus.gnt), 32'(1) << q.owner);
    end
    if (!keep) begin
      bus.req = '0;
      @(negedge clk);
      chk({nm, "_done_pulse"}, 32'({bus.done, bus.gnt}), 0);
    end
  endtask

  initial begin
    logic [7:0] wa;
    bit         seen;
    int         cnt;
    exp_t       q;

    rst_n    = 1'b0;
    stub     = 1'b0;
    bus.req  = '0;
    bus.op_a = '0;
    bus.op_b = '0;

    tbl[0] = mk(2'b01, 8'hA5, 8'h25, 8'h00, 8'h00, 0, 3'b100, 1);
    tbl[1] = mk(2'b10, 8'h00, 8'h00, 8'h3C, 8'h3C, 1, 3'b001, 8);
    tbl[2] = mk(2'b01, 8'h01, 8'h02, 8'h00, 8'h00, 0, 3'b010, 7);
    tbl[3] = mk(2'b10, 8'h00, 8'h00, 8'h80, 8'h00, 1, 3'b100, 1);
    tbl[4] = mk(2'b11, 8'hFF, 8'hFE, 8'h00, 8'h01, 0, 3'b100, 8);
    tbl[5] = mk(2'b11, 8'hFF, 8'hFE, 8'h00, 8'h01, 1, 3'b010, 8);
    tbl[6] = mk(2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 1, 3'b001, 8);
    tbl[7] = mk(2'b11, 8'h40, 8'h80, 8'h7F, 8'h7F, 0, 3'b010, 1);

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), tbl[i].req, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
            tbl[i].e, 1'b0);

    // Bit walk on an equal pair, then reset at idx=4; rr pointer is 1 here.
    wa       = 8'h5A;
    bus.req  = 2'b01;
    bus.op_a = {8'h00, wa};
    bus.op_b = {8'h00, wa};
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("walk_en_%0d", c),  32'(bus.cmp_en), 1);
      chk($sformatf("walk_in1_%0d", c), 32'(bus.cmp_in1), 32'(wa[8-c]));
      chk($sformatf("walk_in2_%0d", c), 32'(bus.cmp_in2), 32'(wa[8-c]));
    end
    rst_n   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check_reset_vals("abort");
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= bus.done;
    end
    chk("abort_no_done", 32'(seen), 0);
    q.owner = 0; q.res = 3'b001; q.k = 8;
    do_op("post_abort", 2'b11, 8'h12, 8'h12, 8'h34, 8'h35, q, 1'b0);

    // Both requesters held continuously from rr_ptr=0.
    do_reset();
    q.owner = 0; q.res = 3'b010; q.k = 7;
    do_op("b2b_r0", 2'b11, 8'h01, 8'h02, 8'h80, 8'h00, q, 1'b1);
    @(negedge clk);
    chk("b2b_idle1", 32'({bus.gnt, bus.done}), 0);
    q.owner = 1; q.res = 3'b100; q.k = 1;
    do_op("b2b_r1", 2'b11, 8'h01, 8'h02, 8'h80, 8'h00, q, 1'b1);
    @(negedge clk);
    chk("b2b_idle2", 32'({bus.gnt, bus.done}), 0);
    q.owner = 0; q.res = 3'b010; q.k = 7;
    do_op("b2b_r0_again", 2'b11, 8'h01, 8'h02, 8'h80, 8'h00, q, 1'b0);

    // Operands and req change after the grant edge must not affect the result.
    bus.req  = 2'b10;
    bus.op_a = {8'h3C, 8'h00};
    bus.op_b = {8'h3D, 8'h00};
    q.owner = 1; q.res = 3'b010; q.k = 8;
    sbq.push_back(q);
    @(negedge clk);
    chk("chg_gnt", 32'(bus.gnt), 32'b10);
    bus.op_a = {8'hFF, 8'hFF};
    bus.req  = '0;
    cnt  = 1;
    seen = 1'b0;
    while (!seen && cnt < WIDTH + 6) begin
      @(negedge clk);
      cnt++;
      if (bus.done) seen = 1'b1;
    end
    q = sbq.pop_front();
    chk("chg_done_seen", 32'(seen), 1);
    chk("chg_latency", cnt, q.k + 1);
    chk("chg_result", 32'({bus.a_gt, bus.b_gt, bus.eq}), 32'(q.res));
    chk("chg_owner", 32'(bus.owner), q.owner);
    @(negedge clk);

    // Comparator stub reports gt and eq together.
    stub = 1'b1;
    q.owner = 0; q.res = 3'b001; q.k = 1;
    do_op("stub", 2'b01, 8'h80, 8'h00, 8'h00, 8'h00, q, 1'b0);
    chk("stub_err_set", 32'(bus.cmp_err), 1);
    stub = 1'b0;
    q.owner = 1; q.res = 3'b100; q.k = 8;
    do_op("after_stub", 2'b10, 8'h00, 8'h00, 8'h01, 8'h00, q, 1'b0);
    chk("stub_err_sticky", 32'(bus.cmp_err), 1);
    do_reset();
    check_reset_vals("final_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
